busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction fetch and sequencing unit. It drives the 4-bit opcode into the `Controle` decoder and receives back the PC-update controls (`EscCP`, `EscCondCP`, `FonteCP`). It owns the program counter and instruction register, and runs a memory request/acknowledge handshake for fetch. It sits between instruction memory, `Controle` and the datapath, and sequences one instruction at a time: fetch, decode, execute, PC update.

## Interface
- `ADDR_W`, 8, program-counter and instruction-memory address width.
- `PC_RESET`, 0, PC value loaded on reset.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mem_req` out 1: fetch request to instruction memory.
- `mem_addr` out ADDR_W: fetch address; always equals `pc`.
- `mem_ack` in 1: memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: instruction word.
- `ir` out 16: instruction register.
- `opcode` out 4: `ir[15:12]`, fed to `Controle`.
- `pc` out ADDR_W: program counter.
- `instr_valida` out 1: high during EXEC; the datapath gates `EscReg` with it.
- `EscCP` in 1: PC write enable from `Controle`.
- `EscCondCP` in 1: conditional PC write from `Controle`.
- `FonteCP` in 2: PC source from `Controle`.
- `zero` in 1: ALU zero flag.
- `alvo_desvio` in ADDR_W: branch target from the ALU.
- `exec_pronto` in 1: datapath has finished the current instruction.

## Operation
- FSM states:
  - OCIOSO: one cycle after reset, then go to BUSCA.
  - BUSCA: `mem_req`=1; stay until `mem_ack`=1, then capture `ir <= mem_rdata` and go to DECOD.
  - DECOD: one cycle, so `Controle` outputs settle on the new `opcode`; go to EXEC.
  - EXEC: `instr_valida`=1; stay until `exec_pronto`=1, then go to ESCREVE_PC.
  - ESCREVE_PC: update the PC, then go to BUSCA.
- PC next-value selection, evaluated in ESCREVE_PC:
  - If `EscCondCP`=1 and `zero`=0: PC+1 (branch not taken).
  - Else if `EscCP`=1, select by `FonteCP`:
    - 00: PC+1.
    - 01: `alvo_desvio`.
    - 10: `ir[11:0]`, zero-extended or truncated to ADDR_W.
    - 11: reserved, treated as PC+1.
  - Else (`EscCP`=0 and `EscCondCP`=0): PC holds, and the same address is fetched again.
- Arithmetic:
  - PC+1 wraps modulo 2^ADDR_W, so all-ones goes to 0.
  - All targets are taken as unsigned values.
- Handshake:
  - `mem_req` stays asserted and `mem_addr` stays stable until the acknowledge.
  - `mem_ack` is ignored in every state except BUSCA.
  - `mem_req` drops in the cycle after the ack edge.
- `ir` and `opcode` change only on the capture edge in BUSCA. `pc` changes only in ESCREVE_PC or on reset.

## Timing
- Reset values:
  - State: OCIOSO.
  - `pc` = `PC_RESET`; `ir` = 0; `opcode` = 0.
  - `mem_req` = 0; `instr_valida` = 0.
- Minimum cycle per instruction is 4 clocks (`mem_ack` and `exec_pronto` each arriving in their first eligible cycle). Each extra wait cycle on either input adds one clock.
- `opcode` becomes valid one cycle before `instr_valida` rises.
- Simultaneous events:
  - `rst` together with `mem_ack`: reset wins and `ir` is not written.
  - `rst` during EXEC: `instr_valida` is 0 on the next cycle and the PC update is discarded.
- A memory ack that arrives late, after a reset abandoned the request, lands outside BUSCA and is ignored.

## Structure
- Shared package `pkg_cpu` holds:
  - Opcode constants 0–15, including `OP_JUMP`=11, `OP_BEQ`=12 and `OP_MUL`=15.
  - `FonteCP` encodings `FCP_SEQ`=00, `FCP_DESVIO`=01, `FCP_SALTO`=10.
  - The FSM state enumeration.
  - The instruction field positions.
- One sub-module: `contador_programa`, containing the PC register plus the next-value mux and wrap logic. The FSM and IR stay in the top level.

## Test plan
- Sequential fetch: reset, then memory acks immediately with words whose opcode is 0. Expect `mem_addr` to step 0,1,2 with a 4-clock period, and `instr_valida` high for exactly 1 cycle per instruction.
- Memory wait: hold `mem_ack` low for 3 cycles. Expect `mem_req` to stay high, `mem_addr` to stay stable and `ir` unchanged; `ir` loads 0xB012 on the ack edge.
- Jump: `ir`=0xB034 with `FonteCP`=10 and `EscCP`=1 → `pc`=0x34. With ADDR_W=8, `ir`=0xB1FF → `pc`=0xFF.
- Branch, `pc`=0x10, `EscCondCP`=1, `FonteCP`=01, `alvo_desvio`=0x40:
  - `zero`=1 → `pc`=0x40.
  - `zero`=0 → `pc`=0x11.
- Wrap: `pc`=0xFF with a sequential update → `pc`=0x00. With `EscCP`=0 and `EscCondCP`=0, `pc` holds 0x05 and address 0x05 is refetched.
- Reset mid-operation: assert `rst` in EXEC and deliver a stray `mem_ack` afterwards. Expect `pc`=`PC_RESET`, `ir`=0 and `instr_valida`=0 next cycle, with the stray ack ignored.

Source files
------------

// File: rtl/pkg_cpu.sv
// pkg_cpu: shared opcodes, PC-source encodings, fetch FSM states and instruction fields
package pkg_cpu;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int END_MSB = 11;
    localparam int END_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_JUMP = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_BNE  = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam logic [1:0] FCP_SEQ    = 2'b00;
    localparam logic [1:0] FCP_DESVIO = 2'b01;
    localparam logic [1:0] FCP_SALTO  = 2'b10;

    typedef enum logic [2:0] {
        OCIOSO,
        BUSCA,
        DECOD,
        EXEC,
        ESCREVE_PC
    } estado_t;

endpackage

// File: rtl/contador_programa.sv
// contador_programa: program counter register with next-value selection and wrap
module contador_programa
    import pkg_cpu::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              escreve,
    input  logic              EscCP,
    input  logic              EscCondCP,
    input  logic [1:0]        FonteCP,
    input  logic              zero,
    input  logic [ADDR_W-1:0] alvo_desvio,
    input  logic [END_MSB:0]  endereco,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] salto;
    logic [ADDR_W-1:0] fonte;
    logic [ADDR_W-1:0] prox;
    logic [ADDR_W+END_MSB:0] ext;

    // a not-taken conditional branch still advances; only with no write request does the PC hold
    always_comb begin
        inc   = pc + 1'b1;
        ext   = {{ADDR_W{1'b0}}, endereco};
        salto = ext[ADDR_W-1:0];
        fonte = (FonteCP == FCP_DESVIO) ? alvo_desvio :
                (FonteCP == FCP_SALTO)  ? salto : inc;
        prox  = (EscCondCP && !zero)   ? inc :
                (EscCP || EscCondCP)   ? fonte : pc;
    end

    // PC register, written only in the PC-update state
    always_ff @(posedge clk) begin
        if (rst)
            pc <= PC_RESET;
        else if (escreve)
            pc <= prox;
    end

endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: fetch/decode/execute/PC-update sequencer with memory handshake
module busca_instrucao
    import pkg_cpu::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valida,
    input  logic               EscCP,
    input  logic               EscCondCP,
    input  logic [1:0]         FonteCP,
    input  logic               zero,
    input  logic [ADDR_W-1:0]  alvo_desvio,
    input  logic               exec_pronto
);

    estado_t estado;
    estado_t prox;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            estado <= OCIOSO;
        else
            estado <= prox;
    end

    // next state and Moore outputs
    always_comb begin
        prox         = estado;
        mem_req      = 1'b0;
        instr_valida = 1'b0;
        unique case (estado)
            OCIOSO:     prox = BUSCA;
            BUSCA: begin
                mem_req = 1'b1;
                if (mem_ack)
                    prox = DECOD;
            end
            DECOD:      prox = EXEC;
            EXEC: begin
                instr_valida = 1'b1;
                if (exec_pronto)
                    prox = ESCREVE_PC;
            end
            ESCREVE_PC: prox = BUSCA;
            default:    prox = OCIOSO;
        endcase
    end

    // instruction register loads only on an acknowledged fetch
    always_ff @(posedge clk) begin
        if (rst)
            ir <= '0;
        else if (estado == BUSCA && mem_ack)
            ir <= mem_rdata;
    end

    assign opcode   = ir[OPC_MSB:OPC_LSB];
    assign mem_addr = pc;

    contador_programa #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .escreve     (estado == ESCREVE_PC),
        .EscCP       (EscCP),
        .EscCondCP   (EscCondCP),
        .FonteCP     (FonteCP),
        .zero        (zero),
        .alvo_desvio (alvo_desvio),
        .endereco    (ir[END_MSB:END_LSB]),
        .pc          (pc)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: randomized and directed checks against a transaction-level model
module tb_busca_instrucao;

    localparam int AW = 8;

    logic          clk = 0;
    logic          rst;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [15:0]   mem_rdata;
    logic [15:0]   ir;
    logic [3:0]    opcode;
    logic [AW-1:0] pc;
    logic          instr_valida;
    logic          EscCP;
    logic          EscCondCP;
    logic [1:0]    FonteCP;
    logic          zero;
    logic [AW-1:0] alvo_desvio;
    logic          exec_pronto;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_pc;
    logic [15:0]   exp_ir;

    busca_instrucao #(.ADDR_W(AW), .PC_RESET(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .ir           (ir),
        .opcode       (opcode),
        .pc           (pc),
        .instr_valida (instr_valida),
        .EscCP        (EscCP),
        .EscCondCP    (EscCondCP),
        .FonteCP      (FonteCP),
        .zero         (zero),
        .alvo_desvio  (alvo_desvio),
        .exec_pronto  (exec_pronto)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] p, input logic [15:0] w,
                                              input logic escp, input logic cond,
                                              input logic [1:0] fcp, input logic z,
                                              input logic [AW-1:0] alvo);
        int inc;
        inc = (int'(p) + 1) % (1 << AW);
        if (cond && !z) return AW'(inc);
        if (!escp && !cond) return p;
        if (fcp == 2'd1) return alvo;
        if (fcp == 2'd2) return AW'((int'(w) % 4096) % (1 << AW));
        return AW'(inc);
    endfunction

    // one instruction, entered and left at a falling edge while the DUT is fetching
    task automatic run_instr(input int d1, input int d2, input logic [15:0] w,
                             input logic escp, input logic cond, input logic [1:0] fcp,
                             input logic z, input logic [AW-1:0] alvo);
        logic [AW-1:0] np;
        verifica("req", 32'(mem_req), 1);
        verifica("addr", 32'(mem_addr), 32'(exp_pc));
        for (int i = 0; i < d1; i++) begin
            mem_ack = 0;
            mem_rdata = 16'($urandom);
            @(negedge clk);
            verifica("req_wait", 32'(mem_req), 1);
            verifica("addr_wait", 32'(mem_addr), 32'(exp_pc));
            verifica("ir_wait", 32'(ir), 32'(exp_ir));
        end
        mem_ack = 1;
        mem_rdata = w;
        @(negedge clk);
        exp_ir = w;
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        verifica("req_drop", 32'(mem_req), 0);
        verifica("ir_load", 32'(ir), 32'(w));
        verifica("opcode", 32'(opcode), 32'(w[15:12]));
        verifica("valida_decod", 32'(instr_valida), 0);
        @(negedge clk);
        EscCP = escp;
        EscCondCP = cond;
        FonteCP = fcp;
        zero = z;
        alvo_desvio = alvo;
        for (int i = 0; i < d2; i++) begin
            exec_pronto = 0;
            mem_ack = 1'($urandom);
            verifica("valida_wait", 32'(instr_valida), 1);
            @(negedge clk);
        end
        exec_pronto = 1;
        verifica("valida", 32'(instr_valida), 1);
        @(negedge clk);
        exec_pronto = 0;
        mem_ack = 1'($urandom);
        verifica("valida_fim", 32'(instr_valida), 0);
        verifica("pc_antes", 32'(pc), 32'(exp_pc));
        verifica("ir_estavel", 32'(ir), 32'(exp_ir));
        np = next_pc(exp_pc, w, escp, cond, fcp, z, alvo);
        @(negedge clk);
        exp_pc = np;
        mem_ack = 0;
        verifica("pc", 32'(pc), 32'(np));
        verifica("ir_mantido", 32'(ir), 32'(exp_ir));
    endtask

    task automatic reset_e_busca();
        int n;
        rst = 1;
        mem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        exp_pc = 8'h00;
        exp_ir = 16'h0000;
        n = 0;
        while (mem_req !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        verifica("busca_apos_reset", 32'(n), 1);
    endtask

    initial begin
        rst = 1;
        mem_ack = 0;
        mem_rdata = 0;
        EscCP = 0;
        EscCondCP = 0;
        FonteCP = 0;
        zero = 0;
        alvo_desvio = 0;
        exec_pronto = 0;
        @(negedge clk);
        @(negedge clk);
        verifica("rst_pc", 32'(pc), 0);
        verifica("rst_ir", 32'(ir), 0);
        verifica("rst_opcode", 32'(opcode), 0);
        verifica("rst_req", 32'(mem_req), 0);
        verifica("rst_valida", 32'(instr_valida), 0);
        reset_e_busca();

        for (int i = 0; i < 3; i++) run_instr(0, 0, 16'h0000, 1, 0, 2'b00, 0, 0);
        run_instr(3, 0, 16'hB012, 1, 0, 2'b00, 0, 0);
        run_instr(0, 0, 16'hB034, 1, 0, 2'b10, 0, 0);
        verifica("jump_34", 32'(pc), 32'h34);
        run_instr(0, 1, 16'hB1FF, 1, 0, 2'b10, 0, 0);
        verifica("jump_ff", 32'(pc), 32'hFF);
        run_instr(1, 0, 16'h0000, 1, 0, 2'b00, 0, 0);
        verifica("wrap", 32'(pc), 0);
        run_instr(0, 0, 16'hB010, 1, 0, 2'b10, 0, 0);
        run_instr(0, 0, 16'hC000, 0, 1, 2'b01, 1, 8'h40);
        verifica("beq_tomado", 32'(pc), 32'h40);
        run_instr(0, 0, 16'hB010, 1, 0, 2'b10, 0, 0);
        run_instr(0, 0, 16'hC000, 0, 1, 2'b01, 0, 8'h40);
        verifica("beq_nao_tomado", 32'(pc), 32'h11);
        run_instr(0, 0, 16'hB005, 1, 0, 2'b10, 0, 0);
        run_instr(0, 0, 16'h0000, 0, 0, 2'b00, 0, 8'h77);
        verifica("pc_parado", 32'(pc), 32'h05);
        run_instr(0, 0, 16'h0000, 1, 0, 2'b11, 0, 8'h77);
        verifica("reservado", 32'(pc), 32'h06);

        for (int i = 0; i < 60; i++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                      1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom));

        // reset arriving during EXEC, then a stray ack while idle
        run_instr(0, 0, 16'hB0A5, 1, 0, 2'b10, 0, 0);
        mem_ack = 1;
        mem_rdata = 16'h9123;
        @(negedge clk);
        mem_ack = 0;
        @(negedge clk);
        verifica("exec_antes_rst", 32'(instr_valida), 1);
        exec_pronto = 1;
        rst = 1;
        @(negedge clk);
        rst = 0;
        exec_pronto = 0;
        verifica("rst_exec_valida", 32'(instr_valida), 0);
        verifica("rst_exec_pc", 32'(pc), 0);
        verifica("rst_exec_ir", 32'(ir), 0);
        mem_ack = 1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 0;
        verifica("ack_perdido_ir", 32'(ir), 0);
        verifica("busca_req", 32'(mem_req), 1);
        verifica("busca_addr", 32'(mem_addr), 0);

        // reset coinciding with an ack in BUSCA does not load ir
        rst = 1;
        mem_ack = 1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        rst = 0;
        mem_ack = 0;
        verifica("rst_ack_ir", 32'(ir), 0);
        verifica("rst_ack_req", 32'(mem_req), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
